serial_subtractor_ctrl: RTL and testbench

Bit-serial subtraction controller. It computes A − B for two WIDTH-bit unsigned operands by sequencing a single 1-bit full-subtractor cell over WIDTH clock cycles, LSB first, and returns the difference and final borrow with a start/busy/done handshake. It sits between a requesting datapath and the one-bit subtractor cell, and replaces a WIDTH-bit parallel subtractor where area matters more than latency.

---
 rtl/serial_subtractor_ctrl_pkg.sv | 14 +
 rtl/serial_subtractor_ctrl_if.sv | 24 ++
 rtl/serial_subtractor_ctrl_full_subtractor.sv | 15 +
 rtl/serial_subtractor_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction controller: FSM states and legal WIDTH bounds.
// Optional zero flag is enabled by defining SERSUB_ZERO_FLAG_EN.
package serial_subtractor_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } sersub_state_e;

   localparam int unsigned SERSUB_WIDTH_MIN = 2;
   localparam int unsigned SERSUB_WIDTH_MAX = 32;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result bundle between a requesting datapath and the serial subtractor.
// The zero port exists only when SERSUB_ZERO_FLAG_EN is defined.
interface serial_subtractor_ctrl_if #(
   parameter int unsigned WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef SERSUB_ZERO_FLAG_EN
   logic             zero;

   modport master (output start, a, b, input busy, done, diff, borrow, zero);
   modport slave  (input start, a, b, output busy, done, diff, borrow, zero);
`else
   modport master (output start, a, b, input busy, done, diff, borrow);
   modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif

endinterface

// File: rtl/serial_subtractor_ctrl_full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin, bout is the borrow out.
module full_subtractor (
   output logic d,
   output logic bout,
   input  logic x,
   input  logic y,
   input  logic bin
);

   always_comb begin
      d    = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
   end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B controller: sequences one full_subtractor cell over WIDTH cycles, LSB first.
// Define SERSUB_ZERO_FLAG_EN to add the registered zero flag.
module serial_subtractor_ctrl
   import serial_subtractor_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   serial_subtractor_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   if (WIDTH < SERSUB_WIDTH_MIN || WIDTH > SERSUB_WIDTH_MAX) begin : g_bad_width
      $error("serial_subtractor_ctrl: WIDTH out of range");
   end

   sersub_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic [WIDTH-1:0] diff_shifted;
   logic             cell_d;
   logic             cell_bout;
`ifdef SERSUB_ZERO_FLAG_EN
   logic             zero_q, zero_d;
`endif

   full_subtractor u_cell (
      .d    (cell_d),
      .bout (cell_bout),
      .x    (a_q[0]),
      .y    (b_q[0]),
      .bin  (borrow_q)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      diff_d       = diff_q;
      borrow_d     = borrow_q;
`ifdef SERSUB_ZERO_FLAG_EN
      zero_d       = zero_q;
`endif
      // cell output enters at the MSB so bit 0 lands at the LSB after WIDTH shifts
      diff_shifted = {cell_d, diff_q[WIDTH-1:1]};

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_RUN;
               a_d      = bus.a;
               b_d      = bus.b;
               diff_d   = '0;
               borrow_d = 1'b0;
               cnt_d    = '0;
`ifdef SERSUB_ZERO_FLAG_EN
               zero_d   = 1'b0;
`endif
            end
         end
         S_RUN: begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            diff_d   = diff_shifted;
            borrow_d = cell_bout;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
`ifdef SERSUB_ZERO_FLAG_EN
               zero_d  = (diff_shifted == '0);
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SERSUB_ZERO_FLAG_EN
         zero_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
`ifdef SERSUB_ZERO_FLAG_EN
         zero_q   <= zero_d;
`endif
      end
   end

   assign bus.busy   = (state_q == S_RUN) || (state_q == S_DONE);
   assign bus.done   = (state_q == S_DONE);
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
`ifdef SERSUB_ZERO_FLAG_EN
   assign bus.zero   = zero_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed checks of serial_subtractor_ctrl at WIDTH=8 plus an exhaustive WIDTH=4 sweep.
// Zero-flag checks are compiled in when SERSUB_ZERO_FLAG_EN is defined.
module tb_serial_subtractor_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   serial_subtractor_ctrl_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_ctrl_if #(.WIDTH(4)) bus4 ();

   serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   serial_subtractor_ctrl #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // called at a negedge; start is high for exactly one rising edge
   task automatic launch8(input logic [7:0] a, input logic [7:0] b);
      bus8.a     = a;
      bus8.b     = b;
      bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      bus8.a     = ~a;
      bus8.b     = ~b;
   endtask

   task automatic finish8(input string tag, input logic [7:0] ed, input logic eb, input logic ez);
      int cyc;
      check({tag, "_busy"}, {31'd0, bus8.busy}, 32'd1);
      cyc = 0;
      while (!bus8.done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_lat"}, cyc, 32'd8);
      check({tag, "_diff"}, {24'd0, bus8.diff}, {24'd0, ed});
      check({tag, "_borrow"}, {31'd0, bus8.borrow}, {31'd0, eb});
`ifdef SERSUB_ZERO_FLAG_EN
      check({tag, "_zero"}, {31'd0, bus8.zero}, {31'd0, ez});
`else
      if (ez) begin end
`endif
      @(negedge clk);
      check({tag, "_idle"}, {30'd0, bus8.busy, bus8.done}, 32'd0);
      check({tag, "_hold"}, {23'd0, bus8.borrow, bus8.diff}, {23'd0, eb, ed});
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic eb, input logic ez);
      @(negedge clk);
      launch8(a, b);
      finish8(tag, ed, eb, ez);
   endtask

   initial begin
      int dones;
      int done_at;
      logic [7:0] got_diff;
      logic got_borrow;

      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_state", {22'd0, bus8.busy, bus8.done, bus8.borrow, bus8.diff}, 32'd0);
`ifdef SERSUB_ZERO_FLAG_EN
      check("rst_zero", {31'd0, bus8.zero}, 32'd1);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_hold", {30'd0, bus8.busy, bus8.done}, 32'd0);

      op8("v0503", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
      op8("v0305", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
      op8("v0001", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
      op8("vFFFF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
      op8("v807F", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);
      op8("v00FF", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

      // start pulse mid-RUN with new operands must be ignored
      @(negedge clk);
      launch8(8'h10, 8'h01);
      dones = 0; done_at = 0; got_diff = '0; got_borrow = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         if (i == 3) begin
            bus8.start = 1'b1;
            bus8.a     = 8'h77;
            bus8.b     = 8'h11;
         end
         if (i == 4) bus8.start = 1'b0;
         @(negedge clk);
         if (bus8.done) begin
            dones++;
            done_at    = i;
            got_diff   = bus8.diff;
            got_borrow = bus8.borrow;
         end
      end
      check("ign_dones", dones, 32'd1);
      check("ign_when", done_at, 32'd8);
      check("ign_diff", {23'd0, got_borrow, got_diff}, {23'd0, 1'b0, 8'h0F});
      check("ign_hold", {24'd0, bus8.diff}, 32'h0F);

      // back-to-back: start raised in the first idle cycle after done
      op8("b2b_a", 8'h40, 8'h41, 8'hFF, 1'b1, 1'b0);
      launch8(8'h20, 8'h08);
      finish8("b2b_b", 8'h18, 1'b0, 1'b0);

      // asynchronous reset mid-RUN discards the partial result
      @(negedge clk);
      launch8(8'hAA, 8'h55);
      repeat (3) @(negedge clk);
      check("abort_partial", {31'd0, bus8.diff != 8'h00}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_rst", {22'd0, bus8.busy, bus8.done, bus8.borrow, bus8.diff}, 32'd0);
`ifdef SERSUB_ZERO_FLAG_EN
      check("abort_zero", {31'd0, bus8.zero}, 32'd1);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      op8("after_abort", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

      // exhaustive WIDTH=4 sweep
      for (int unsigned x = 0; x < 16; x++) begin
         for (int unsigned y = 0; y < 16; y++) begin
            int cyc;
            logic [3:0] ed;
            logic eb;
            ed = 4'(x - y);
            eb = (x < y);
            @(negedge clk);
            bus4.a     = 4'(x);
            bus4.b     = 4'(y);
            bus4.start = 1'b1;
            @(negedge clk);
            bus4.start = 1'b0;
            cyc = 0;
            while (!bus4.done && cyc < 20) begin
               @(negedge clk);
               cyc++;
            end
            check($sformatf("sweep_%0h_%0h", x, y),
                  {19'd0, 8'(cyc), eb, ed}, {19'd0, 8'd4, eb, ed} & 32'hFFFF_FFFF);
            if (cyc == 4)
               check($sformatf("sweep_val_%0h_%0h", x, y), {27'd0, bus4.borrow, bus4.diff}, {27'd0, eb, ed});
`ifdef SERSUB_ZERO_FLAG_EN
            check($sformatf("sweep_zero_%0h_%0h", x, y), {31'd0, bus4.zero}, {31'd0, ed == 4'd0});
`endif
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
